// File: rtl/cache2vias_ctrl.sv
// rtl/cache2vias_ctrl.sv - CPU/cache/memory sequencing controller for cache2vias
module cache2vias_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [4:0]       cpu_addr,
  input  logic [7:0]       cpu_wdata,
  output logic             cpu_ack,
  output logic [7:0]       cpu_rdata,
  output logic             cpu_hit,
  output logic             busy,
  output logic [4:0]       cache_addr,
  output logic             cache_wren,
  output logic [7:0]       cache_wdata,
  input  logic             cache_hit,
  input  logic [7:0]       cache_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [4:0]       mem_addr,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, CHECK, MEM_RD, FILL, MEM_WR, DONE
  } state_t;

  state_t     state;
  logic       req_we;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      cpu_hit     <= 1'b0;
      busy        <= 1'b0;
      cache_addr  <= '0;
      cache_wren  <= 1'b0;
      cache_wdata <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      cpu_ack    <= 1'b0;
      cache_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we     <= cpu_we;
            req_addr   <= cpu_addr;
            req_wdata  <= cpu_wdata;
            cache_addr <= cpu_addr;
            busy       <= 1'b1;
            state      <= LOOKUP;
          end
        end
        LOOKUP: state <= CHECK;
        CHECK: begin
          cpu_hit <= cache_hit;
          if (cache_hit) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
          end
          if (req_we) begin
            cache_wren  <= 1'b1;
            cache_wdata <= req_wdata;
            state       <= FILL;
          end else if (cache_hit) begin
            cpu_rdata <= cache_rdata;
            cpu_ack   <= 1'b1;
            state     <= DONE;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= req_addr;
            state    <= MEM_RD;
          end
        end
        // cache_wdata doubles as the fill register for read misses
        MEM_RD: begin
          if (mem_ack) begin
            mem_req     <= 1'b0;
            cpu_rdata   <= mem_rdata;
            cache_wdata <= mem_rdata;
            cache_wren  <= 1'b1;
            state       <= FILL;
          end
        end
        FILL: begin
          if (req_we) begin
            state <= MEM_WR;
          end else begin
            cpu_ack <= 1'b1;
            state   <= DONE;
          end
        end
        // First MEM_WR cycle only issues the write-through; ack is honoured once mem_req is up
        MEM_WR: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache2vias_ctrl.sv
// tb/tb_cache2vias_ctrl.sv - randomized self-checking bench for cache2vias_ctrl
module tb_cache2vias_ctrl;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             resetn;
  logic             cpu_req, cpu_we;
  logic [4:0]       cpu_addr;
  logic [7:0]       cpu_wdata;
  logic             cpu_ack, cpu_hit, busy;
  logic [7:0]       cpu_rdata;
  logic [4:0]       cache_addr;
  logic             cache_wren;
  logic [7:0]       cache_wdata;
  logic             cache_hit;
  logic [7:0]       cache_rdata;
  logic             mem_req, mem_we;
  logic [4:0]       mem_addr;
  logic [7:0]       mem_wdata, mem_rdata;
  logic             mem_ack;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_hits, m_misses;
  logic [7:0] m_rdata;

  cache2vias_ctrl #(.CNT_W(CNT_W)) dut (
    .clock(clock), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit), .busy(busy),
    .cache_addr(cache_addr), .cache_wren(cache_wren), .cache_wdata(cache_wdata),
    .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    m_hits = 0;
    m_misses = 0;
    m_rdata = 8'h00;
  endtask

  // One complete CPU transaction against a scripted cache/memory environment
  task automatic do_req(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                        input logic hit, input logic [7:0] crd, input int lat,
                        input logic [7:0] mrd);
    int cyc = 0, memcnt = 0, wrcnt = 0, ackcyc = -1;
    int exp_ack, exp_mem, exp_wr;
    logic [4:0] wr_a = '0, ma = '0;
    logic [7:0] wr_d = '0, mwd = '0, ack_rd = '0;
    logic       mwe = 1'b0, ack_hit = 1'b0, busy_bad = 1'b0, mem_bad = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    cache_hit = hit; cache_rdata = crd; mem_rdata = mrd; mem_ack = 1'b0;
    while (ackcyc < 0 && cyc < 60) begin
      tick();
      cyc++;
      cpu_req = 1'b0;
      cpu_we = 1'($urandom);
      cpu_addr = 5'($urandom);
      cpu_wdata = 8'($urandom);
      if (!busy) busy_bad = 1'b1;
      if (mem_req) begin
        memcnt++;
        if (memcnt == 1) begin
          mwe = mem_we; ma = mem_addr; mwd = mem_wdata;
        end else if ({mem_we, mem_addr, mem_wdata} != {mwe, ma, mwd}) begin
          mem_bad = 1'b1;
        end
        mem_ack = (memcnt == lat);
      end else begin
        mem_ack = 1'b0;
      end
      if (cache_wren) begin
        wrcnt++; wr_a = cache_addr; wr_d = cache_wdata;
      end
      if (cpu_ack) begin
        ackcyc = cyc; ack_rd = cpu_rdata; ack_hit = cpu_hit;
      end
    end
    mem_ack = 1'b0;

    exp_ack = we ? 5 + lat : (hit ? 3 : 4 + lat);
    exp_mem = (hit && !we) ? 0 : lat;
    exp_wr  = (hit && !we) ? 0 : 1;
    if (!we) m_rdata = hit ? crd : mrd;
    if (hit) begin
      if (m_hits < MAXC) m_hits++;
    end else begin
      if (m_misses < MAXC) m_misses++;
    end

    check("ack_cycle", ackcyc, exp_ack);
    check("rdata", ack_rd, m_rdata);
    check("cpu_hit", ack_hit, hit);
    check("busy_high", busy_bad, 0);
    check("wren_cycles", wrcnt, exp_wr);
    if (exp_wr == 1) begin
      check("fill_addr", wr_a, addr);
      check("fill_data", wr_d, we ? wdata : mrd);
    end
    check("mem_cycles", memcnt, exp_mem);
    if (exp_mem > 0) begin
      check("mem_stable", mem_bad, 0);
      check("mem_we", mwe, we);
      check("mem_addr", ma, addr);
      if (we) check("mem_wdata", mwd, wdata);
    end
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
    tick();
    check("idle_busy", busy, 0);
    check("ack_pulse", cpu_ack, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, acks, bad;
    logic [31:0] sat_seq [5];
    sat_seq = '{1, 2, 3, 3, 3};
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cache_hit = 1'b0; cache_rdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    do_reset();
    check("rst_outputs",
          {cpu_ack, cpu_hit, busy, cache_wren, mem_req, mem_we, cpu_rdata, cache_wdata,
           mem_wdata, cache_addr, mem_addr}, 0);
    check("rst_counters", {hit_cnt, miss_cnt}, 0);

    do_req(1'b0, 5'h09, 8'h00, 1'b0, 8'h00, 2, 8'hA5);
    do_req(1'b0, 5'h09, 8'h00, 1'b1, 8'hA5, 1, 8'h00);
    do_req(1'b1, 5'h1A, 8'h3C, 1'b0, 8'h00, 3, 8'h00);

    // Reset in the middle of a memory read; the late ack must be ignored
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h0C; cache_hit = 1'b0; mem_rdata = 8'h77;
    bad = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      cpu_req = 1'b0;
      if (c == 3) begin
        check("mid_memrd_req", mem_req, 1);
        resetn = 1'b0;
      end else if (c == 4) begin
        resetn = 1'b1;
        mem_ack = 1'b1;
        check("post_rst_req", mem_req, 0);
        check("post_rst_busy", busy, 0);
      end else begin
        mem_ack = 1'b0;
      end
      if (c >= 4 && (cpu_ack || cache_wren || mem_req || busy)) bad++;
    end
    check("rst_ignored_ack", bad, 0);
    m_hits = 0; m_misses = 0; m_rdata = 8'h00;
    check("rst_rdata", cpu_rdata, 0);
    check("rst_miss_cnt", miss_cnt, 0);

    // Held request: two back-to-back read hits
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h09; cache_hit = 1'b1; cache_rdata = 8'h5A;
    a1 = -1; a2 = -1; acks = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (cpu_ack) begin
        acks++;
        if (a1 < 0) a1 = c; else if (a2 < 0) a2 = c;
        if (acks == 2) cpu_req = 1'b0;
      end
    end
    check("b2b_acks", acks, 2);
    check("b2b_first", a1, 3);
    check("b2b_gap", a2 - a1, 4);
    check("b2b_hit_cnt", hit_cnt, 2);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, 5'($urandom), 8'h00, 1'b1, 8'($urandom), 1, 8'h00);
      check("sat_hit_cnt", hit_cnt, sat_seq[i]);
    end

    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) do_reset();
      do_req(1'($urandom), 5'($urandom), 8'($urandom), 1'($urandom),
             8'($urandom), int'($urandom_range(1, 4)), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
